// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: aligns stores, extends loads and runs
// a req/ack handshake to variable-latency data memory, stalling meanwhile.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] alu_data_M,
  input  logic [31:0] st_data_M,
  input  logic [2:0]  funct3_M,
  input  logic        mem_wren_M,
  input  logic        mem_rden_M,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_bmask,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] ld_data_M,
  output logic        o_ld_valid,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_ld_data;
  logic [3:0]  r_bmask;
  logic        r_we;
  logic        r_load;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_misalign;
  logic        r_timeout;

  logic        w_access;
  logic        w_mis;
  logic        w_go;
  logic [31:0] w_wdata;
  logic [3:0]  w_bmask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_access = mem_wren_M | mem_rden_M;
  assign w_mis = (funct3_M[1:0] == 2'b01 && alu_data_M[0])
              || (funct3_M[1]   && alu_data_M[1:0] != 2'b00);
  assign w_go = (r_state == S_IDLE) && w_access && !w_mis;

  always_comb begin
    w_wdata = st_data_M;
    w_bmask = 4'hF;
    if (mem_wren_M) begin
      unique case (funct3_M)
        3'b000: begin
          w_wdata = {4{st_data_M[7:0]}};
          w_bmask = 4'b0001 << alu_data_M[1:0];
        end
        3'b001: begin
          w_wdata = {2{st_data_M[15:0]}};
          w_bmask = 4'b0011 << {alu_data_M[1], 1'b0};
        end
        default: begin
          w_wdata = st_data_M;
          w_bmask = 4'hF;
        end
      endcase
    end
  end

  assign w_byte = 8'(i_dmem_rdata >> {r_off, 3'b000});
  assign w_half = r_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    unique case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_ld_data  <= 32'd0;
      r_bmask    <= 4'd0;
      r_we       <= 1'b0;
      r_load     <= 1'b0;
      r_f3       <= 3'd0;
      r_off      <= 2'd0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_BUSY;
            r_cnt   <= 8'd0;
            r_addr  <= {alu_data_M[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_bmask <= w_bmask;
            r_we    <= mem_wren_M;
            r_load  <= !mem_wren_M;
            r_f3    <= funct3_M;
            r_off   <= alu_data_M[1:0];
          end else if (w_access) begin
            r_misalign <= 1'b1;
            if (!mem_wren_M)
              r_ld_data <= 32'd0;
          end
        end
        S_BUSY: begin
          if (i_dmem_ack) begin
            if (r_load)
              r_ld_data <= w_ext;
            r_state <= S_DONE;
          end else if (r_cnt == LP_LAST) begin
            r_timeout <= 1'b1;
            r_ld_data <= 32'd0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The held instruction is still visible in DONE; it must not restart.
  assign o_stall      = !i_rst && (w_go || r_state == S_BUSY);
  assign o_dmem_req   = (r_state == S_BUSY);
  assign o_dmem_we    = r_we;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_wdata = r_wdata;
  assign o_dmem_bmask = r_bmask;
  assign ld_data_M    = r_ld_data;
  assign o_ld_valid   = (r_state == S_DONE) && r_load;
  assign o_misalign   = r_misalign;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed table, hand sequences for reset and
// spurious ack, and randomized accesses against a behavioural model.
module tb_mem_stage_lsu;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] alu_data_M, st_data_M, i_dmem_rdata;
  logic [2:0]  funct3_M;
  logic        mem_wren_M, mem_rden_M, i_dmem_ack;
  logic        o_dmem_req, o_dmem_we, o_ld_valid, o_stall;
  logic        o_misalign, o_timeout;
  logic [31:0] o_dmem_addr, o_dmem_wdata, ld_data_M;
  logic [3:0]  o_dmem_bmask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .alu_data_M(alu_data_M), .st_data_M(st_data_M),
    .funct3_M(funct3_M), .mem_wren_M(mem_wren_M),
    .mem_rden_M(mem_rden_M), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_bmask(o_dmem_bmask),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .ld_data_M(ld_data_M), .o_ld_valid(o_ld_valid),
    .o_stall(o_stall), .o_misalign(o_misalign),
    .o_timeout(o_timeout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] st;
    logic [2:0]  f3;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] ld;
    logic [31:0] wd;
    logic [3:0]  bm;
    logic        mis;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    alu_data_M = 0; st_data_M = 0; funct3_M = 0;
    mem_wren_M = 0; mem_rden_M = 0; i_dmem_rdata = 0;
  endtask

  // Behavioural model: plain arithmetic on bytes and halves.
  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned off = a % 4;
    logic [31:0] b = (rd >> (8 * off)) & 32'hFF;
    logic [31:0] h = (rd >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f3,
                                 input logic [31:0] a);
    int unsigned sz = f3 % 4;
    if (sz == 1) return (a % 2) != 0;
    if (sz >= 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] st);
    if (f3 == 0) return (st & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (st & 32'hFFFF) * 32'h0001_0001;
    return st;
  endfunction

  function automatic logic [3:0] m_bm(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a);
    if (!we) return 4'hF;
    if (f3 == 0) return 4'(1 << (a % 4));
    if (f3 == 1) return 4'(3 << (a % 4 / 2 * 2));
    return 4'hF;
  endfunction

  task automatic run_acc(input vec_t v, input string tag);
    logic ld;
    int nb;
    ld = v.re && !v.we;
    @(posedge clk); #1;
    alu_data_M = v.a; st_data_M = v.st; funct3_M = v.f3;
    mem_wren_M = v.we; mem_rden_M = v.re;
    i_dmem_rdata = v.rdata; i_dmem_ack = 0;
    @(negedge clk);
    if (v.mis) begin
      chk({tag, " mis stall"}, o_stall, 0);
      chk({tag, " mis req"}, o_dmem_req, 0);
      @(posedge clk); #1; clr_inputs();
      @(negedge clk);
      chk({tag, " misalign"}, o_misalign, 1);
      chk({tag, " mis req2"}, o_dmem_req, 0);
      chk({tag, " mis ldv"}, o_ld_valid, 0);
      if (ld) chk({tag, " mis ld"}, ld_data_M, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " misalign end"}, o_misalign, 0);
      return;
    end
    chk({tag, " stall0"}, o_stall, 1);
    chk({tag, " req0"}, o_dmem_req, 0);
    nb = (v.dly < MW) ? v.dly + 1 : MW;
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      i_dmem_ack = (k == v.dly);
      @(negedge clk);
      chk({tag, " req"}, o_dmem_req, 1);
      chk({tag, " stall"}, o_stall, 1);
      chk({tag, " addr"}, o_dmem_addr, v.a & 32'hFFFF_FFFC);
      chk({tag, " we"}, o_dmem_we, v.we);
      chk({tag, " bmask"}, o_dmem_bmask, v.bm);
      if (v.we) chk({tag, " wdata"}, o_dmem_wdata, v.wd);
    end
    @(posedge clk); #1;
    i_dmem_ack = 0;
    @(negedge clk);
    chk({tag, " done stall"}, o_stall, 0);
    chk({tag, " done req"}, o_dmem_req, 0);
    chk({tag, " ld_valid"}, o_ld_valid, ld);
    chk({tag, " timeout"}, o_timeout, v.dly >= MW);
    chk({tag, " misalign0"}, o_misalign, 0);
    if (ld) chk({tag, " ld_data"}, ld_data_M, v.ld);
    @(posedge clk); #1;
    clr_inputs();
    i_dmem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({tag, " idle stall"}, o_stall, 0);
    chk({tag, " idle req"}, o_dmem_req, 0);
    chk({tag, " idle ldv"}, o_ld_valid, 0);
    chk({tag, " idle tmo"}, o_timeout, 0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, st, input logic [2:0] f3,
                              input logic we, re, input logic [31:0] rd,
                              input int dly, input logic [31:0] ld, wd,
                              input logic [3:0] bm, input logic mis);
    vec_t v;
    v.a = a; v.st = st; v.f3 = f3; v.we = we; v.re = re; v.rdata = rd;
    v.dly = dly; v.ld = ld; v.wd = wd; v.bm = bm; v.mis = mis;
    return v;
  endfunction

  initial begin
    vec_t v;
    tbl[0]  = mk(32'h103, 0, 3'd0, 0, 1, 32'h80FF_1234, 0,
                 32'hFFFF_FF80, 0, 4'hF, 0);
    tbl[1]  = mk(32'h102, 0, 3'd5, 0, 1, 32'h8001_0000, 3,
                 32'h0000_8001, 0, 4'hF, 0);
    tbl[2]  = mk(32'h201, 32'hAB, 3'd0, 1, 0, 0, 1,
                 0, 32'hABAB_ABAB, 4'b0010, 0);
    tbl[3]  = mk(32'h006, 0, 3'd2, 0, 1, 0, 0, 0, 0, 4'hF, 1);
    tbl[4]  = mk(32'h040, 0, 3'd2, 0, 1, 32'h1234_5678, 20,
                 0, 0, 4'hF, 0);
    tbl[5]  = mk(32'h002, 0, 3'd1, 0, 1, 32'h8001_7FFF, 0,
                 32'hFFFF_8001, 0, 4'hF, 0);
    tbl[6]  = mk(32'h102, 32'h1234_CDEF, 3'd1, 1, 0, 0, 2,
                 0, 32'hCDEF_CDEF, 4'b1100, 0);
    tbl[7]  = mk(32'h040, 32'hDEAD_BEEF, 3'd2, 1, 0, 0, 0,
                 0, 32'hDEAD_BEEF, 4'hF, 0);
    tbl[8]  = mk(32'h001, 0, 3'd4, 0, 1, 32'h0000_F500, 1,
                 32'h0000_00F5, 0, 4'hF, 0);
    tbl[9]  = mk(32'h103, 32'h55, 3'd1, 1, 0, 0, 0, 0, 0, 4'hF, 1);
    tbl[10] = mk(32'h003, 32'h5A, 3'd0, 1, 1, 32'hFFFF_FFFF, 0,
                 0, 32'h5A5A_5A5A, 4'b1000, 0);
    tbl[11] = mk(32'h008, 0, 3'd3, 0, 1, 32'hCAFE_BABE, 2,
                 32'hCAFE_BABE, 0, 4'hF, 0);
    tbl[12] = mk(32'h00C, 0, 3'd2, 0, 1, 32'h0000_0011, MW - 1,
                 32'h0000_0011, 0, 4'hF, 0);

    i_rst = 1; i_dmem_ack = 0; clr_inputs();
    repeat (2) @(posedge clk);
    #1; i_rst = 0;
    @(negedge clk);
    chk("rst req", o_dmem_req, 0);
    chk("rst stall", o_stall, 0);
    chk("rst ldv", o_ld_valid, 0);
    chk("rst mis", o_misalign, 0);
    chk("rst tmo", o_timeout, 0);
    chk("rst addr", o_dmem_addr, 0);
    chk("rst wdata", o_dmem_wdata, 0);
    chk("rst bmask", o_dmem_bmask, 0);
    chk("rst we", o_dmem_we, 0);
    chk("rst ld", ld_data_M, 0);

    for (int i = 0; i < 13; i++) run_acc(tbl[i], $sformatf("tbl%0d", i));

    // Ack while idle must not produce a result.
    @(posedge clk); #1; clr_inputs(); i_dmem_ack = 1;
    @(negedge clk);
    @(posedge clk); #1; i_dmem_ack = 0;
    @(negedge clk);
    chk("stray ack ldv", o_ld_valid, 0);
    chk("stray ack req", o_dmem_req, 0);

    // Reset in the second BUSY cycle, ack arriving one cycle late.
    @(posedge clk); #1;
    alu_data_M = 32'h10; funct3_M = 3'd2; mem_rden_M = 1;
    i_dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstb busy1 req", o_dmem_req, 1);
    @(posedge clk); #1;
    i_rst = 1; clr_inputs();
    @(posedge clk); #1;
    i_rst = 0; i_dmem_ack = 1;
    @(negedge clk);
    chk("rstb req", o_dmem_req, 0);
    chk("rstb stall", o_stall, 0);
    chk("rstb ldv", o_ld_valid, 0);
    chk("rstb addr", o_dmem_addr, 0);
    chk("rstb bmask", o_dmem_bmask, 0);
    chk("rstb ld", ld_data_M, 0);
    @(posedge clk); #1; i_dmem_ack = 0;
    @(negedge clk);
    chk("rstb ldv2", o_ld_valid, 0);
    chk("rstb req2", o_dmem_req, 0);

    for (int i = 0; i < 60; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.re = v.we ? 1'($urandom_range(0, 1)) : 1'b1;
      v.f3 = v.we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      v.a = $urandom;
      if ($urandom_range(0, 2) != 0) v.a = v.a & ~32'h3;
      v.st = $urandom;
      v.rdata = $urandom;
      v.dly = $urandom_range(0, MW + 1);
      v.mis = m_mis(v.f3, v.a);
      v.ld = (v.dly >= MW) ? 32'h0 : m_load(v.f3, v.a, v.rdata);
      v.wd = m_wd(v.f3, v.st);
      v.bm = m_bm(v.we, v.f3, v.a);
      run_acc(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage load/store unit. Consumes the EX/MEM pipeline register outputs (address from ALU result, funct3, write enable, load enable, store data) and drives a variable-latency data memory port through a req/ack handshake. It performs byte-lane alignment, sign/zero extension and misalignment detection. While an access is outstanding it stalls the pipeline, then presents the load result to the MEM/WB register.

Parameters:
MAX_WAIT, 255, maximum BUSY cycles without ack before the access is aborted (8-bit counter; legal range 1..255)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
alu_data_M  in  32  effective byte address
st_data_M  in  32  store data (rs2 value)
funct3_M  in  3  access size/sign
mem_wren_M  in  1  store request
mem_rden_M  in  1  load request
o_dmem_req  out  1  memory request, held until ack or timeout
o_dmem_we  out  1  1 = write
o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  out  32  lane-replicated store data
o_dmem_bmask  out  4  byte enables
i_dmem_ack  in  1  memory completion
i_dmem_rdata  in  32  memory read word
ld_data_M  out  32  extended load result (registered)
o_ld_valid  out  1  1-cycle pulse: ld_data_M valid
o_stall  out  1  hold upstream pipeline registers
o_misalign  out  1  1-cycle pulse: misaligned access dropped
o_timeout  out  1  1-cycle pulse: access aborted

Behaviour:
- Reset (sync, i_rst high at posedge): state=IDLE, wait counter=0, all outputs 0. A reset during BUSY drops o_dmem_req at that edge; a late ack is ignored.
- Access = mem_wren_M | mem_rden_M. If both are high, treat it as a store and ignore the load.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. No memory request is issued, o_stall stays 0, and o_misalign pulses on the next cycle. For a load, ld_data_M=0 with o_ld_valid=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on an aligned access, latch addr/we/wdata/bmask/funct3/offset and go to BUSY.
  - BUSY: o_dmem_req=1. On i_dmem_ack, capture the extended rdata into ld_data_M (loads only) and go to DONE. If the counter reaches MAX_WAIT without ack, drop req, pulse o_timeout, set ld_data_M=0 and go to DONE.
  - DONE: o_ld_valid=1 for loads, o_stall=0, then go unconditionally to IDLE. The held instruction must not retrigger.
- o_stall is combinational: (IDLE & aligned access) | BUSY. Upstream therefore holds from the first cycle the access is seen.
- Minimum latency (ack in the first BUSY cycle): 2 stall cycles, with o_ld_valid in the 3rd cycle.
- i_dmem_ack outside BUSY is ignored.
- The wait counter clears on entry to BUSY.
- Loads, by funct3:
  - 000 LB: sign-extend the byte at lane addr[1:0].
  - 100 LBU: zero-extend the same byte.
  - 001 LH: sign-extend the half at addr[1].
  - 101 LHU: zero-extend the same half.
  - 010 LW: full word.
  - 011/110/111: treated as LW.
- Stores, by funct3:
  - 000 SB: bmask=4'b0001<<addr[1:0], wdata={4{st[7:0]}}.
  - 001 SH: bmask=4'b0011<<{addr[1],1'b0}, wdata={2{st[15:0]}}.
  - 010 SW and others: bmask=4'hF, wdata=st.
- For loads, o_dmem_we=0 and bmask=4'hF.
- o_dmem_addr/wdata/bmask/we come from latched registers and are stable for the whole of BUSY.

Test Plan:
- LB at addr 0x103, rdata 0x80FF_1234, ack in the 1st BUSY cycle -> stall high for 2 cycles, then ld_data_M=0xFFFF_FF80 with o_ld_valid for 1 cycle.
- LHU at 0x102, rdata 0x8001_0000, ack after 4 BUSY cycles -> stall high 5 cycles, ld_data_M=0x0000_8001, req held steady until ack.
- SB at 0x201 with st_data 0x0000_00AB -> addr=0x200, bmask=4'b0010, wdata=0xABAB_ABAB, we=1, o_ld_valid stays 0.
- LW at 0x006 -> no req, o_stall=0, o_misalign pulses 1 cycle.
- Load with no ack, MAX_WAIT=8 -> req drops after 8 BUSY cycles, o_timeout pulses, ld_data_M=0.
- i_rst asserted in the 2nd BUSY cycle, ack in the next cycle -> all outputs 0 from that edge, no o_ld_valid.
